// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer feeding one RGB frame through the Sobel pipeline and storing its results.
// Optional cycle_cnt_o statistics port enabled by defining SOBEL_FRAME_CTRL_STATS_EN.
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH     = 8,
  parameter int IMG_HEIGHT    = 8,
  parameter int ADDR_W        = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              timeout_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [23:0]       rd_data_i,
  output logic [7:0]        data_red_o,
  output logic [7:0]        data_green_o,
  output logic [7:0]        data_blue_o,
  output logic              data_done_o,
  input  logic [7:0]        sobel_red_i,
  input  logic [7:0]        sobel_green_i,
  input  logic [7:0]        sobel_blue_i,
  input  logic              sobel_done_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [23:0]       wr_data_o
`ifdef SOBEL_FRAME_CTRL_STATS_EN
  ,
  output logic [31:0]       cycle_cnt_o
`endif
);

  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int DW = (DRAIN_TIMEOUT < 1) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [ADDR_W:0] N_CNT  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0] N_LAST = (ADDR_W + 1)'(N - 1);
  localparam logic [DW-1:0]   DT     = DW'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   wr_cnt_nxt;
  logic [DW-1:0]     drain_cnt;
  logic [23:0]       data_hold;
  logic              wr_fire;

  always_comb begin
    wr_fire    = sobel_done_i && ((state == FETCH) || (state == DRAIN)) && (wr_cnt < N_CNT);
    wr_cnt_nxt = wr_fire ? wr_cnt + 1'b1 : wr_cnt;
  end

  assign wr_en_o   = wr_fire;
  assign wr_addr_o = wr_fire ? wr_cnt[ADDR_W-1:0] : '0;
  assign wr_data_o = wr_fire ? {sobel_red_i, sobel_green_i, sobel_blue_i} : '0;

  // RAM data arrives alongside data_done_o, so it is forwarded on the strobe
  // and captured into data_hold to keep the last pixel steady between strobes.
  assign {data_red_o, data_green_o, data_blue_o} = data_done_o ? rd_data_i : data_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      drain_cnt    <= '0;
      data_hold    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      timeout_o    <= 1'b0;
      rd_en_o      <= 1'b0;
      rd_addr_o    <= '0;
      data_done_o  <= 1'b0;
    end else begin
      wr_cnt       <= wr_cnt_nxt;
      data_done_o  <= rd_en_o;
      frame_done_o <= 1'b0;
      if (data_done_o) data_hold <= rd_data_i;

      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= FETCH;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            drain_cnt <= '0;
            timeout_o <= 1'b0;
            busy_o    <= 1'b1;
            rd_en_o   <= 1'b1;
            rd_addr_o <= '0;
          end
        end
        FETCH: begin
          if (rd_cnt == N_LAST) begin
            state     <= DRAIN;
            rd_en_o   <= 1'b0;
            drain_cnt <= '0;
          end else begin
            rd_cnt    <= rd_cnt + 1'b1;
            rd_addr_o <= rd_cnt[ADDR_W-1:0] + 1'b1;
          end
        end
        DRAIN: begin
          if (wr_cnt_nxt == N_CNT) begin
            state        <= DONE;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b1;
          end else if (drain_cnt == DT) begin
            state        <= DONE;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b1;
            timeout_o    <= 1'b1;
          end else begin
            drain_cnt <= sobel_done_i ? '0 : drain_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SOBEL_FRAME_CTRL_STATS_EN
  // The accepting IDLE cycle counts as the first cycle of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_o <= '0;
    end else if (state == IDLE) begin
      if (start_i) cycle_cnt_o <= 32'd1;
    end else if (cycle_cnt_o != '1) begin
      cycle_cnt_o <= cycle_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: 4x4 frame, latency-5 pipeline model, source RAM model.
module tb_sobel_frame_ctrl;

  localparam int N   = 16;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, frame_done_o, timeout_o, rd_en_o, data_done_o, wr_en_o;
  logic [15:0] rd_addr_o, wr_addr_o;
  logic [23:0] rd_data_i = '0;
  logic [23:0] wr_data_o;
  logic [7:0]  data_red_o, data_green_o, data_blue_o;
  logic [7:0]  sobel_red_i, sobel_green_i, sobel_blue_i;
  logic        sobel_done_i;
`ifdef SOBEL_FRAME_CTRL_STATS_EN
  logic [31:0] cycle_cnt_o;
`endif

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .IMG_WIDTH(4),
    .IMG_HEIGHT(4),
    .ADDR_W(16),
    .DRAIN_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .timeout_o(timeout_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .data_red_o(data_red_o), .data_green_o(data_green_o), .data_blue_o(data_blue_o),
    .data_done_o(data_done_o),
    .sobel_red_i(sobel_red_i), .sobel_green_i(sobel_green_i), .sobel_blue_i(sobel_blue_i),
    .sobel_done_i(sobel_done_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
`ifdef SOBEL_FRAME_CTRL_STATS_EN
    , .cycle_cnt_o(cycle_cnt_o)
`endif
  );

  function automatic logic [23:0] pix(input int i);
    return 24'(i * 32'h0A1B2C + 32'h123456);
  endfunction

  function automatic logic [23:0] xf(input logic [23:0] p);
    return {~p[15:8], p[7:0] ^ 8'h5A, p[23:16]};
  endfunction

  logic [23:0] mem [0:N-1];
  initial for (int i = 0; i < N; i++) mem[i] = pix(i);

  always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o[3:0]];

  // Fixed-latency pipeline model with fault knobs: drop the last strobe, add one extra.
  logic        clr_req = 1'b0;
  bit          drop_last = 1'b0, add_extra = 1'b0;
  logic [LAT-1:0] pd = '0;
  logic [23:0] pv [0:LAT-1];
  int          in_cnt = 0;
  logic        dd_prev = 1'b0;
  logic        inj;

  assign inj = (data_done_o && !(drop_last && in_cnt == N - 1)) ||
               (add_extra && dd_prev && !data_done_o);

  always @(posedge clk) begin
    pd    <= {pd[LAT-2:0], inj};
    pv[0] <= xf({data_red_o, data_green_o, data_blue_o});
    for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1];
    dd_prev <= data_done_o;
    if (clr_req) in_cnt <= 0;
    else if (data_done_o) in_cnt <= in_cnt + 1;
  end

  assign sobel_done_i = pd[LAT-1];
  assign {sobel_red_i, sobel_green_i, sobel_blue_i} = pv[LAT-1];

  // Per-frame observation, cycle 0 being the cycle in which start_i is driven.
  int cyc, n_rd, rd_bad, rd_first, rd_last, n_dd, dd_bad, n_wr, wr_bad, n_fd, fd_cyc, n_busy;

  always @(negedge clk) begin
    if (clr_req) begin
      cyc = 0; n_rd = 0; rd_bad = 0; rd_first = -1; rd_last = -1;
      n_dd = 0; dd_bad = 0; n_wr = 0; wr_bad = 0; n_fd = 0; fd_cyc = -1; n_busy = 0;
    end else begin
      cyc++;
      if (rd_en_o) begin
        if (rd_addr_o != 16'(n_rd)) rd_bad++;
        if (n_rd == 0) rd_first = cyc;
        rd_last = cyc;
        n_rd++;
      end
      if (data_done_o) begin
        if (n_dd >= N) dd_bad++;
        else if ({data_red_o, data_green_o, data_blue_o} != mem[n_dd]) dd_bad++;
        n_dd++;
      end
      if (wr_en_o) begin
        if (n_wr >= N) wr_bad++;
        else if (wr_addr_o != 16'(n_wr) || wr_data_o != xf(mem[n_wr])) wr_bad++;
        n_wr++;
      end
      if (frame_done_o) begin
        n_fd++;
        fd_cyc = cyc;
      end
      if (busy_o) n_busy++;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_set();
    return $countones({busy_o, frame_done_o, timeout_o, rd_en_o, rd_addr_o,
                       data_red_o, data_green_o, data_blue_o, data_done_o,
                       wr_en_o, wr_addr_o, wr_data_o});
  endfunction

  typedef struct {
    string name;
    bit    restart;
    bit    drop;
    bit    extra;
    int    exp_wr;
    int    exp_done;
    bit    exp_to;
  } scen_t;

  scen_t tbl [0:3];

  task automatic start_frame();
    @(posedge clk); #1;
    start_i = 1'b1;
    clr_req = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic run_frame(input int k);
    string nm;
    nm        = tbl[k].name;
    drop_last = tbl[k].drop;
    add_extra = tbl[k].extra;
    start_frame();
    chk({nm, "_timeout_clr"}, int'(timeout_o), 0);
    chk({nm, "_busy_set"}, int'(busy_o), 1);
    if (tbl[k].restart) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    for (int c = 0; c < 400 && n_fd == 0; c++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    chk({nm, "_reads"}, n_rd, N);
    chk({nm, "_rd_addr_bad"}, rd_bad, 0);
    chk({nm, "_rd_first"}, rd_first, 1);
    chk({nm, "_rd_span"}, rd_last - rd_first + 1, N);
    chk({nm, "_strobes"}, n_dd, N);
    chk({nm, "_pix_bad"}, dd_bad, 0);
    chk({nm, "_writes"}, n_wr, tbl[k].exp_wr);
    chk({nm, "_wr_bad"}, wr_bad, 0);
    chk({nm, "_done_pulses"}, n_fd, 1);
    chk({nm, "_done_cycle"}, fd_cyc, tbl[k].exp_done);
    chk({nm, "_busy_cycles"}, n_busy, tbl[k].exp_done - 1);
    chk({nm, "_timeout"}, int'(timeout_o), int'(tbl[k].exp_to));
    chk({nm, "_busy_after"}, int'(busy_o), 0);
`ifdef SOBEL_FRAME_CTRL_STATS_EN
    if (k == 0) begin
      chk({nm, "_cycle_cnt"}, int'(cycle_cnt_o), N + LAT + 3);
      repeat (5) @(posedge clk);
      #1;
      chk({nm, "_cycle_cnt_hold"}, int'(cycle_cnt_o), N + LAT + 3);
    end
`endif
    drop_last = 1'b0;
    add_extra = 1'b0;
  endtask

  initial begin
    int found, sd_seen, we_seen;
    tbl[0] = '{"normal",  1'b0, 1'b0, 1'b0, 16, N + LAT + 2, 1'b0};
    tbl[1] = '{"restart", 1'b1, 1'b0, 1'b0, 16, N + LAT + 2, 1'b0};
    tbl[2] = '{"short",   1'b0, 1'b1, 1'b0, 15, 87,          1'b1};
    tbl[3] = '{"extra",   1'b0, 1'b0, 1'b1, 16, N + LAT + 2, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs_set(), 0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) run_frame(k);

    // Reset in the middle of FETCH, then confirm late pipeline strobes are ignored.
    start_frame();
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      if (rd_en_o && rd_addr_o == 16'd7) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("rst_reached_addr7", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_outputs", outs_set(), 0);
    sd_seen = 0;
    we_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (sobel_done_i) sd_seen++;
      if (wr_en_o) we_seen++;
      if (busy_o || rd_en_o) we_seen++;
      @(posedge clk); #1;
    end
    chk("rst_late_strobes_present", int'(sd_seen > 0), 1);
    chk("rst_late_writes", we_seen, 0);
    chk("rst_no_timeout", int'(timeout_o), 0);

    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
Name:
sobel_frame_ctrl

Overview:
- Frame sequencer for the Sobel edge pipeline (RGB-to-grayscale, kernel, grayscale-to-RGB chain).
- On a start pulse, streams one frame of RGB pixels from a source pixel RAM into the pipeline, one pixel per cycle, with a valid strobe.
- Captures every pipeline output strobe and writes the result to a destination RAM at sequential addresses.
- Reports busy, frame-done and timeout status to the system controller.

Parameters:
- IMG_WIDTH, 8, pixels per line.
- IMG_HEIGHT, 8, lines per frame.
- ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- DRAIN_TIMEOUT, 64, maximum cycles to wait for outstanding pipeline outputs after the last fetch.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  single-cycle frame start request
- busy_o  out  1  high from accepted start until frame completion
- frame_done_o  out  1  one-cycle pulse at frame completion
- timeout_o  out  1  sticky error flag: drain timed out; cleared by rst or next accepted start
- rd_en_o  out  1  source RAM read enable
- rd_addr_o  out  ADDR_W  source RAM read address
- rd_data_i  in  24  source pixel {R[23:16], G[15:8], B[7:0]}; valid exactly 1 cycle after rd_en_o
- data_red_o  out  8  pixel red to pipeline
- data_green_o  out  8  pixel green to pipeline
- data_blue_o  out  8  pixel blue to pipeline
- data_done_o  out  1  pipeline input valid strobe
- sobel_red_i  in  8  pipeline output red
- sobel_green_i  in  8  pipeline output green
- sobel_blue_i  in  8  pipeline output blue
- sobel_done_i  in  1  pipeline output valid strobe
- wr_en_o  out  1  destination RAM write enable
- wr_addr_o  out  ADDR_W  destination RAM write address
- wr_data_o  out  24  destination data {R, G, B}

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous, active-high.
  - All outputs reset to 0.
  - State returns to IDLE; all counters cleared.
  - rst mid-frame abandons the frame immediately.
  - No frame_done_o pulse; pipeline outputs arriving after reset are ignored.
- N = IMG_WIDTH*IMG_HEIGHT.
- States:
  - IDLE: start_i=1 -> FETCH. On transition: clear rd/wr counters, clear timeout_o, set busy_o.
  - FETCH: assert rd_en_o every cycle, rd_addr_o = rd_cnt, rd_cnt++. When rd_cnt = N-1 is issued -> DRAIN.
  - DRAIN: rd_en_o=0. Drain counter increments each cycle and resets to 0 on every sobel_done_i.
    - wr_cnt reaches N -> DONE.
    - Drain counter reaches DRAIN_TIMEOUT -> set timeout_o, -> DONE.
  - DONE: frame_done_o=1 for exactly one cycle, busy_o=0, -> IDLE.
- start_i while busy_o=1 is ignored (no restart, no queueing).
- Input path:
  - data_done_o = rd_en_o delayed 1 cycle.
  - data_*_o = rd_data_i registered on that strobe; hold the last value otherwise.
  - Exactly N strobes per frame, on consecutive cycles.
- Output path (active in FETCH and DRAIN):
  - On sobel_done_i: wr_en_o=1 the same cycle, wr_addr_o=wr_cnt, wr_data_o={sobel_red_i, sobel_green_i, sobel_blue_i}, wr_cnt++. Combinational from the inputs, gated by state.
  - Strobes beyond N, or in IDLE/DONE, are dropped with wr_en_o=0.
- Reads and writes may occur in the same cycle. No stall path exists: the pipeline is fixed-latency and must accept one pixel per cycle.
- Minimum frame time: N + pipeline latency + 2 cycles from start to frame_done_o.
- Counters are ADDR_W+1 bits wide. Addresses never wrap within a frame.

Optional Feature:
- Macro: SOBEL_FRAME_CTRL_STATS_EN.
- When defined, adds output port cycle_cnt_o [31:0].
  - Counts cycles from accepted start through the DONE cycle inclusive.
  - Holds its value in IDLE until the next accepted start clears it.
  - Saturates at 0xFFFFFFFF.
  - Resets to 0 on rst.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pipeline model with latency 5, start pulse -> 16 consecutive rd_en_o at addresses 0..15; 16 data_done_o strobes; 16 writes at addresses 0..15 with matching data; frame_done_o one cycle; busy_o low afterwards; timeout_o=0.
- start_i reasserted at cycle 3 of FETCH -> ignored; still exactly 16 reads, 16 writes, one frame_done_o.
- Pipeline model outputs only 15 strobes, DRAIN_TIMEOUT=64 -> timeout_o=1 after 64 idle drain cycles; frame_done_o pulses; wr_addr_o never reaches 15.
- rst asserted mid-FETCH at rd_cnt=7 -> next cycle all outputs 0, state IDLE; late sobel_done_i strobes produce no wr_en_o; new start runs a clean full frame.
- Extra sobel_done_i strobe after 16 writes (before DONE) -> dropped, wr_en_o=0.
- With SOBEL_FRAME_CTRL_STATS_EN, latency-5 model -> cycle_cnt_o = 16+5+2 ±1 after frame; value holds until next start.
